vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
- Raster timing generator and pixel sink for the VGA path.
- Scans 640x480@60 Hz timing from the system clock via a pixel-enable divider.
- Drives `pix_x`/`pix_y` to vga_screen_pic and samples its combinational `rgb` return.
- Emits registered, sync-aligned `hsync`, `vsync` and `vga_rgb` to the connector, plus a once-per-frame tick for game-state update.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); legal values >= 1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rgb  in  12  pixel colour from vga_screen_pic for the current pix_x/pix_y
- pix_x  out  10  column being requested; 0 outside active region
- pix_y  out  9  row being requested; 0 outside active region
- pix_valid  out  1  current h_cnt/v_cnt inside active region
- hsync  out  1  horizontal sync to connector
- vsync  out  1  vertical sync to connector
- vga_rgb  out  12  colour to DAC; zero during blanking
- frame_tick  out  1  one-clk pulse at start of vertical blanking

Behaviour:
- Reset: synchronous, active-low; sampled on `clk` rising edge; overrides everything, including mid-frame.
  - Values after a reset edge: div=0, h_cnt=0, v_cnt=0, vga_rgb=0, frame_tick=0.
  - hsync = vsync = ~SYNC_POL (deasserted).
  - Combinational outputs therefore read pix_x=0, pix_y=0, pix_valid=1.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div == CLK_DIV-1); with CLK_DIV=1, pix_en is 1 every cycle.
  - First pix_en occurs on the CLK_DIV-th clk edge after rst_n goes high.
- Counters: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
  - On pix_en, h_cnt increments and wraps at H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps at V_TOTAL-1 -> 0.
  - Counters hold between pix_en pulses.
- Coordinate outputs (combinational from counters):
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pix_valid = active.
  - pix_x = active ? h_cnt[9:0] : 0; pix_y = active ? v_cnt[8:0] : 0.
- Output stage: one pixel of latency, all three outputs updated on the same pix_en.
  - vga_rgb <= pix_valid ? rgb : 12'h000.
  - hsync <= (h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) ? SYNC_POL : ~SYNC_POL. Default window is 656..751.
  - vsync <= (v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]) ? SYNC_POL : ~SYNC_POL. Default window is 490..491.
  - rgb is sampled only on pix_en cycles; its value between pix_en pulses is don't-care.
- frame_tick:
  - Registered; 1 for exactly one clk cycle, on the edge after the pix_en where h_cnt==H_TOTAL-1 and v_cnt==V_ACTIVE-1.
  - Otherwise 0.
  - Exactly one pulse per frame (V_TOTAL*H_TOTAL pixel ticks).
- Widths: h_cnt is 10 bits and v_cnt is 10 bits internally; v_cnt truncates to 9 bits for pix_y (valid only while active).

Test Plan:
- Reset and startup: hold rst_n=0 for 5 clks, then release; mid-frame variant asserts rst_n=0 at h_cnt=300, v_cnt=200 for 1 clk.
  - During reset: vga_rgb=0, hsync=vsync=1, pix_x=0, pix_y=0, frame_tick=0.
  - After release: first pix_x change (0->1) on the 4th clk edge after release.
  - Mid-frame variant: next cycle shows h_cnt=0, v_cnt=0, outputs at reset values.
- Line timing: count pix_en over one line.
  - pix_x sweeps 0..639 with pix_valid=1, then pix_valid=0 for 160 pixels.
  - hsync low for exactly 96 pixels, beginning one pixel after h_cnt reaches 656.
  - Line period is 3200 clks.
- Frame timing: run 2 frames.
  - vsync low for exactly 2 lines (6400 clks), starting one pixel after v_cnt=490, h_cnt=0.
  - frame_tick pulses once per frame, each pulse 1 clk wide; pulses are 1,680,000 clks apart.
- Colour pipeline and blanking: drive rgb = {pix_x[3:0], pix_y[3:0], 4'hA}.
  - vga_rgb equals the value presented one pixel earlier; e.g. pixel (5,7) appears as 12'h57A on the following pixel slot.
  - vga_rgb=0 during blanking even with rgb forced to 12'hFFF.
- CLK_DIV=1 build: pix_en every cycle; line period is 800 clks; frame_tick period is 420,000 clks.
- SYNC_POL=1 build: hsync and vsync polarity inverted (idle 0, pulse 1) with identical pulse positions.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator and pixel sink; counters advance on a divided pixel enable.
// One pixel slot of latency from rgb to vga_rgb/hsync/vsync; no backpressure, rgb is sampled on pix_en only.
module vga_timing_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] rgb,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        pix_valid,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] vga_rgb,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_h_cnt;
   logic [9:0]       r_v_cnt;
   logic [11:0]      r_vga_rgb;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_frame_tick;

   logic w_pix_en;
   logic w_active;
   logic w_h_wrap;
   logic w_v_wrap;
   logic w_hs_win;
   logic w_vs_win;
   logic w_frame_end;

   // With CLK_DIV == 1 the divider is a constant 0 and DIV_LAST is 0, so pix_en is stuck high.
   assign w_pix_en    = (r_div == DIV_LAST);
   assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign w_h_wrap    = (r_h_cnt == H_LAST);
   assign w_v_wrap    = (r_v_cnt == V_LAST);
   assign w_hs_win    = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
   assign w_vs_win    = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
   assign w_frame_end = w_h_wrap && (r_v_cnt == V_ACT_M1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_div <= '0;
      end else if (w_pix_en) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_pix_en) begin
         if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   // Colour and syncs move together so the DAC sees them aligned to the same pixel slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vga_rgb    <= '0;
         r_hsync      <= ~SYNC_POL;
         r_vsync      <= ~SYNC_POL;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= 1'b0;
         if (w_pix_en) begin
            r_vga_rgb    <= w_active ? rgb : 12'h000;
            r_hsync      <= w_hs_win ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vs_win ? SYNC_POL : ~SYNC_POL;
            r_frame_tick <= w_frame_end;
         end
      end
   end

   assign pix_valid  = w_active;
   assign pix_x      = w_active ? r_h_cnt : 10'd0;
   assign pix_y      = w_active ? r_v_cnt[8:0] : 9'd0;
   assign hsync      = r_hsync;
   assign vsync      = r_vsync;
   assign vga_rgb    = r_vga_rgb;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: two shrunken-raster instances (CLK_DIV=3/active-low, CLK_DIV=1/active-high)
// checked every cycle against an arithmetic model derived from the clock count since reset.
module tb_vga_timing_ctrl;

   localparam int HA = 16, HF = 4, HS = 6, HB = 4;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int N_CYC = 6000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] rnd0, rnd1;
   int          mode;

   logic [11:0] rgb0, rgb1, vrgb0, vrgb1;
   logic [9:0]  px0, px1;
   logic [8:0]  py0, py1;
   logic        pv0, pv1, hs0, hs1, vs0, vs1, ft0, ft1;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint cyc      = 0;
   bit     started  = 1'b0;

   longint      k[2];
   logic [11:0] erg[2];
   longint      last_tick[2];
   int          exp_ticks[2];
   int          obs_ticks[2];
   int          cdv[2];
   bit          pol[2];

   always #5 clk = ~clk;

   vga_timing_ctrl #(
      .CLK_DIV(3), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rgb(rgb0), .pix_x(px0), .pix_y(py0), .pix_valid(pv0),
      .hsync(hs0), .vsync(vs0), .vga_rgb(vrgb0), .frame_tick(ft0)
   );

   vga_timing_ctrl #(
      .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rgb(rgb1), .pix_x(px1), .pix_y(py1), .pix_valid(pv1),
      .hsync(hs1), .vsync(vs1), .vga_rgb(vrgb1), .frame_tick(ft1)
   );

   assign rgb0 = (mode == 1) ? {px0[3:0], py0[3:0], 4'hA} : (mode == 2) ? 12'hFFF : rnd0;
   assign rgb1 = (mode == 1) ? {px1[3:0], py1[3:0], 4'hA} : (mode == 2) ? 12'hFFF : rnd1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   // Pixel index p counts pix_en edges since reset; counters are p mod raster size.
   task automatic model_step(input int d);
      longint p, prv;
      int h, v;
      logic [11:0] smp;
      if (!rst_n) begin
         k[d] = 0;
         erg[d] = 12'h000;
         last_tick[d] = -1;
      end else begin
         k[d]++;
         if (k[d] % cdv[d] == 0) begin
            p   = k[d] / cdv[d];
            prv = p - 1;
            h   = int'(prv % HT);
            v   = int'((prv / HT) % VT);
            smp = (mode == 1) ? {4'(h), 4'(v), 4'hA} : (mode == 2) ? 12'hFFF : ((d == 0) ? rnd0 : rnd1);
            erg[d] = (h < HA && v < VA) ? smp : 12'h000;
            if (h == HT - 1 && v == VA - 1) exp_ticks[d]++;
         end
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0);
      model_step(1);
      started = 1'b1;
   end

   task automatic check_dut(input int d, input logic [9:0] x, input logic [8:0] y, input logic val,
                            input logic hs, input logic vs, input logic [11:0] vr, input logic ft);
      longint p, prv;
      int h, v, ph, pv;
      bit act, e_hs, e_vs, e_ft;
      string s;
      s   = (d == 0) ? "d0" : "d1";
      p   = k[d] / cdv[d];
      h   = int'(p % HT);
      v   = int'((p / HT) % VT);
      act = (h < HA) && (v < VA);
      e_hs = ~pol[d];
      e_vs = ~pol[d];
      e_ft = 1'b0;
      if (p > 0) begin
         prv = p - 1;
         ph  = int'(prv % HT);
         pv  = int'((prv / HT) % VT);
         if (ph >= HA + HF && ph < HA + HF + HS) e_hs = pol[d];
         if (pv >= VA + VF && pv < VA + VF + VS) e_vs = pol[d];
         e_ft = (k[d] % cdv[d] == 0) && (ph == HT - 1) && (pv == VA - 1);
      end
      chk({s, "_pix_valid"}, longint'(val), longint'(act));
      chk({s, "_pix_x"}, longint'(x), act ? longint'(h) : 0);
      chk({s, "_pix_y"}, longint'(y), act ? longint'(v) : 0);
      chk({s, "_hsync"}, longint'(hs), longint'(e_hs));
      chk({s, "_vsync"}, longint'(vs), longint'(e_vs));
      chk({s, "_vga_rgb"}, longint'(vr), longint'(erg[d]));
      chk({s, "_frame_tick"}, longint'(ft), longint'(e_ft));
      if (ft) begin
         obs_ticks[d]++;
         if (last_tick[d] >= 0) chk({s, "_tick_period"}, cyc - last_tick[d], longint'(cdv[d] * HT * VT));
         last_tick[d] = cyc;
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check_dut(0, px0, py0, pv0, hs0, vs0, vrgb0, ft0);
         check_dut(1, px1, py1, pv1, hs1, vs1, vrgb1, ft1);
      end
   end

   initial begin
      cdv[0] = 3; cdv[1] = 1;
      pol[0] = 1'b0; pol[1] = 1'b1;
      for (int d = 0; d < 2; d++) begin
         k[d] = 0; erg[d] = 12'h000; last_tick[d] = -1; exp_ticks[d] = 0; obs_ticks[d] = 0;
      end
      rst_n = 1'b0;
      mode  = 1;
      rnd0  = 12'($urandom);
      rnd1  = 12'($urandom);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N_CYC; i++) begin
         @(negedge clk);
         rnd0 = 12'($urandom);
         rnd1 = 12'($urandom);
         if (i >= 1500 && i % 200 == 0) mode = int'($urandom_range(0, 2));
         if (i == 2345 || i == 4000 + int'($urandom_range(0, 500))) rst_n = 1'b0;
         else rst_n = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk((d == 0) ? "d0_tick_count" : "d1_tick_count", longint'(obs_ticks[d]), longint'(exp_ticks[d]));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
